// File: rtl/board_b_gfx_rom_arbiter.sv
// Tile-ROM fetch arbiter: collects one-shot fetch pulses from the background layer engines,
// serves them round-robin over one toggle-handshake SDRAM channel and returns each word with rdy.
module board_b_gfx_rom_arbiter #(
  parameter int                NUM_LAYERS = 3,
  parameter int                MEM_AW     = 25,
  parameter logic [MEM_AW-1:0] ROM_BASE   = '0
) (
  input  logic                     CLK_32M,
  input  logic                     RESET,
  input  logic [NUM_LAYERS-1:0]    layer_req,
  input  logic [NUM_LAYERS*21-1:0] layer_addr,
  output logic [31:0]              layer_data,
  output logic [NUM_LAYERS-1:0]    layer_rdy,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic                     mem_req,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_data
);

  localparam int IW = (NUM_LAYERS > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  typedef logic [20:0] addr_t;

  state_t                state, state_nx;
  logic [NUM_LAYERS-1:0] pend, pend_nx;
  addr_t                 slot_addr    [NUM_LAYERS];
  addr_t                 slot_addr_nx [NUM_LAYERS];
  logic [IW-1:0]         rr, rr_nx;
  logic [IW-1:0]         cur, cur_nx;
  logic [IW-1:0]         win;
  logic [IW:0]           cand;
  logic                  win_found;
  logic [MEM_AW-1:0]     mem_addr_nx;
  logic                  mem_req_nx;
  logic [31:0]           layer_data_nx;
  logic [NUM_LAYERS-1:0] layer_rdy_nx;
  logic                  xfer_done;

  assign xfer_done = (mem_ack == mem_req);

  // Winner is the first registered pending slot at or after rr, wrapping modulo NUM_LAYERS.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      cand = {1'b0, rr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_LAYERS)) cand = cand - (IW+1)'(NUM_LAYERS);
      if (!win_found && pend[cand[IW-1:0]]) begin
        win       = cand[IW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx      = state;
    pend_nx       = pend;
    slot_addr_nx  = slot_addr;
    rr_nx         = rr;
    cur_nx        = cur;
    mem_addr_nx   = mem_addr;
    mem_req_nx    = mem_req;
    layer_data_nx = layer_data;
    layer_rdy_nx  = '0;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          mem_addr_nx   = MEM_AW'(slot_addr[win]) + ROM_BASE;
          mem_req_nx    = ~mem_req;
          pend_nx[win]  = 1'b0;
          cur_nx        = win;
          rr_nx         = (win == IW'(NUM_LAYERS-1)) ? '0 : win + IW'(1);
          state_nx      = BUSY;
        end
      end
      BUSY: begin
        if (xfer_done) begin
          layer_data_nx     = mem_data;
          layer_rdy_nx[cur] = 1'b1;
          state_nx          = IDLE;
        end
      end
      DRAIN: begin
        if (xfer_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // New requests land after the grant, so a req on the granted slot becomes a fresh pending fetch.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_req[i]) begin
        pend_nx[i]      = 1'b1;
        slot_addr_nx[i] = layer_addr[21*i +: 21];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state      <= (mem_req != mem_ack) ? DRAIN : IDLE;
      pend       <= '0;
      rr         <= '0;
      cur        <= '0;
      mem_addr   <= '0;
      layer_data <= '0;
      layer_rdy  <= '0;
      // NOTE: the slot array is cleared too so no stale address survives reset into a later fetch.
      for (int i = 0; i < NUM_LAYERS; i++) slot_addr[i] <= '0;
    end else begin
      state      <= state_nx;
      pend       <= pend_nx;
      slot_addr  <= slot_addr_nx;
      rr         <= rr_nx;
      cur        <= cur_nx;
      mem_addr   <= mem_addr_nx;
      layer_data <= layer_data_nx;
      layer_rdy  <= layer_rdy_nx;
    end
  end

  // mem_req keeps its level through reset; an in-flight request is drained, never re-issued.
  always_ff @(posedge CLK_32M) begin
    if (!RESET) mem_req <= mem_req_nx;
  end

endmodule

// File: tb/tb_board_b_gfx_rom_arbiter.sv
// Bench for board_b_gfx_rom_arbiter: lockstep behavioural model plus scenario tasks; a second
// instance with a high ROM_BASE shares all inputs to exercise address wrap.
module tb_board_b_gfx_rom_arbiter;

  localparam int          N      = 3;
  localparam logic [24:0] BASE_A = 25'h0100000;
  localparam logic [24:0] BASE_W = 25'h1FFFFF0;

  logic        CLK_32M = 1'b0;
  logic        RESET = 1'b1;
  logic [2:0]  layer_req = '0;
  logic [62:0] layer_addr = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] layer_data, layer_data_w;
  logic [2:0]  layer_rdy, layer_rdy_w;
  logic [24:0] mem_addr, mem_addr_w;
  logic        mem_req, mem_req_w;

  board_b_gfx_rom_arbiter #(.NUM_LAYERS(N), .MEM_AW(25), .ROM_BASE(BASE_A)) dut_a (
    .CLK_32M(CLK_32M), .RESET(RESET), .layer_req(layer_req), .layer_addr(layer_addr),
    .layer_data(layer_data), .layer_rdy(layer_rdy), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data));

  board_b_gfx_rom_arbiter #(.NUM_LAYERS(N), .MEM_AW(25), .ROM_BASE(BASE_W)) dut_w (
    .CLK_32M(CLK_32M), .RESET(RESET), .layer_req(layer_req), .layer_addr(layer_addr),
    .layer_data(layer_data_w), .layer_rdy(layer_rdy_w), .mem_addr(mem_addr_w), .mem_req(mem_req_w),
    .mem_ack(mem_ack), .mem_data(mem_data));

  always #5 CLK_32M = ~CLK_32M;

  int n_vec = 0;
  int n_err = 0;

  // SDRAM responder settings
  int          mem_lat   = 3;
  bit          rand_lat  = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  bit          resp_busy = 1'b0;
  int          resp_cnt  = 0;

  // Behavioural model: pending flags/addresses, rr pointer, in-flight layer (-1 none), drain flag
  bit          m_pend [N];
  logic [20:0] m_addr [N];
  int          m_rr = 0;
  int          m_cur = -1;
  bit          m_drain = 1'b0;
  logic        m_req = 1'b0;
  logic [24:0] m_maddr = '0;
  logic [24:0] m_maddr_w = '0;
  logic [31:0] m_data = '0;
  logic [2:0]  m_rdy = '0;

  int          obs_rdy [$];
  logic [24:0] obs_addr [$];
  logic [24:0] obs_addr_w [$];

  function automatic logic [31:0] data_of(input logic [24:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [24:0] rom_addr(input logic [20:0] a, input logic [24:0] base);
    longint unsigned s;
    s = 64'(a) + 64'(base);
    return 25'(s % (64'd1 << 25));
  endfunction

  function automatic bit model_idle();
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) any |= m_pend[i];
    return (m_cur < 0) && !m_drain && !any;
  endfunction

  function automatic void clear_obs();
    obs_rdy.delete();
    obs_addr.delete();
    obs_addr_w.delete();
  endfunction

  // One clock: drive inputs, run responder and model, then compare both DUTs after the edge.
  task automatic tick(input logic [2:0] req, input logic [20:0] a0, input logic [20:0] a1,
                      input logic [20:0] a2, input logic rst);
    logic [20:0] av [N];
    int          g;
    logic        prev;
    av[0] = a0; av[1] = a1; av[2] = a2;
    RESET      = rst;
    layer_req  = req;
    layer_addr = {a2, a1, a0};

    if (mem_req !== mem_ack) begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        resp_cnt  = rand_lat ? int'($urandom_range(1, 6)) : mem_lat;
      end
      if (resp_cnt <= 1) begin
        mem_ack   = mem_req;
        mem_data  = use_fixed ? fixed_data : data_of(mem_addr);
        resp_busy = 1'b0;
      end else begin
        resp_cnt--;
      end
    end

    m_rdy = '0;
    if (rst) begin
      m_data = '0; m_maddr = '0; m_maddr_w = '0; m_rr = 0; m_cur = -1;
      m_drain = (m_req != mem_ack);
      for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; m_addr[i] = '0; end
    end else begin
      g = -1;
      if (m_drain) begin
        if (mem_ack == m_req) m_drain = 1'b0;
      end else if (m_cur >= 0) begin
        if (mem_ack == m_req) begin
          m_data = mem_data; m_rdy[m_cur] = 1'b1; m_cur = -1;
        end
      end else begin
        for (int k = 0; k < N; k++) if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) begin
          m_maddr   = rom_addr(m_addr[g], BASE_A);
          m_maddr_w = rom_addr(m_addr[g], BASE_W);
          m_req     = ~m_req;
          m_pend[g] = 1'b0;
          m_cur     = g;
          m_rr      = (g + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) if (req[i]) begin m_pend[i] = 1'b1; m_addr[i] = av[i]; end
    end

    prev = mem_req;
    @(posedge CLK_32M);
    @(negedge CLK_32M);

    n_vec++; if (mem_req !== m_req) begin n_err++; $display("FAIL mem_req: got %b want %b", mem_req, m_req); end
    n_vec++; if (mem_addr !== m_maddr) begin n_err++; $display("FAIL mem_addr: got %h want %h", mem_addr, m_maddr); end
    n_vec++; if (layer_rdy !== m_rdy) begin n_err++; $display("FAIL layer_rdy: got %b want %b", layer_rdy, m_rdy); end
    n_vec++; if (layer_data !== m_data) begin n_err++; $display("FAIL layer_data: got %h want %h", layer_data, m_data); end
    n_vec++; if (mem_req_w !== m_req) begin n_err++; $display("FAIL wrap_mem_req: got %b want %b", mem_req_w, m_req); end
    n_vec++; if (mem_addr_w !== m_maddr_w) begin n_err++; $display("FAIL wrap_mem_addr: got %h want %h", mem_addr_w, m_maddr_w); end
    n_vec++; if (layer_rdy_w !== m_rdy) begin n_err++; $display("FAIL wrap_layer_rdy: got %b want %b", layer_rdy_w, m_rdy); end
    n_vec++; if (layer_data_w !== m_data) begin n_err++; $display("FAIL wrap_layer_data: got %h want %h", layer_data_w, m_data); end

    for (int i = 0; i < N; i++) if (layer_rdy[i] === 1'b1) obs_rdy.push_back(i);
    if (mem_req !== prev) begin
      obs_addr.push_back(mem_addr);
      obs_addr_w.push_back(mem_addr_w);
    end
  endtask

  task automatic idle_tick();
    tick(3'b000, '0, '0, '0, 1'b0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!model_idle() && t < 80) begin idle_tick(); t++; end
    n_vec++;
    if (t >= 80) begin n_err++; $display("FAIL idle_timeout: got %0d cycles want < 80", t); end
  endtask

  task automatic test_reset();
    repeat (3) tick(3'b000, '0, '0, '0, 1'b1);
    n_vec++; if (layer_rdy !== 3'b000) begin n_err++; $display("FAIL reset_rdy: got %b want 000", layer_rdy); end
    n_vec++; if (layer_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", layer_data); end
    n_vec++; if (mem_addr !== 25'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    idle_tick();
  endtask

  task automatic test_single();
    logic r0;
    int   t;
    mem_lat = 5; use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
    clear_obs();
    r0 = m_req;
    tick(3'b010, '0, 21'h00A40, '0, 1'b0);
    n_vec++; if (mem_req !== r0) begin n_err++; $display("FAIL single_no_early_toggle: got %b want %b", mem_req, r0); end
    idle_tick();
    n_vec++; if (mem_req !== ~r0) begin n_err++; $display("FAIL single_toggle_k1: got %b want %b", mem_req, ~r0); end
    n_vec++; if (mem_addr !== 25'h0100A40) begin n_err++; $display("FAIL single_addr: got %h want 0100a40", mem_addr); end
    n_vec++; if (mem_addr_w !== 25'h0000A30) begin n_err++; $display("FAIL single_addr_wrap: got %h want 0000a30", mem_addr_w); end
    t = 0;
    while (layer_rdy === 3'b000 && t < 20) begin idle_tick(); t++; end
    n_vec++; if (layer_rdy !== 3'b010) begin n_err++; $display("FAIL single_rdy: got %b want 010", layer_rdy); end
    n_vec++; if (layer_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", layer_data); end
    idle_tick();
    n_vec++; if (layer_rdy !== 3'b000) begin n_err++; $display("FAIL single_rdy_pulse: got %b want 000", layer_rdy); end
    n_vec++; if (layer_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data_hold: got %h want deadbeef", layer_data); end
    use_fixed = 1'b0;
    wait_idle();
  endtask

  task automatic test_all_layers();
    int          exp_o [3];
    logic [24:0] exp_a [3];
    exp_o = '{0, 1, 2};
    exp_a = '{25'h0100100, 25'h0100200, 25'h0100300};
    mem_lat = 3;
    repeat (2) tick(3'b000, '0, '0, '0, 1'b1);
    clear_obs();
    tick(3'b111, 21'h100, 21'h200, 21'h300, 1'b0);
    wait_idle();
    n_vec++; if (obs_rdy.size() != 3) begin n_err++; $display("FAIL all_rdy_count: got %0d want 3", obs_rdy.size()); end
    for (int i = 0; i < 3 && i < obs_rdy.size() && i < obs_addr.size(); i++) begin
      n_vec++; if (obs_rdy[i] != exp_o[i]) begin n_err++; $display("FAIL all_order[%0d]: got %0d want %0d", i, obs_rdy[i], exp_o[i]); end
      n_vec++; if (obs_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL all_addr[%0d]: got %h want %h", i, obs_addr[i], exp_a[i]); end
    end
    tick(3'b001, 21'h400, '0, '0, 1'b0);
    wait_idle();
    clear_obs();
    tick(3'b101, 21'h500, '0, 21'h600, 1'b0);
    wait_idle();
    n_vec++;
    if (obs_rdy.size() != 2 || obs_addr.size() != 2) begin
      n_err++; $display("FAIL burst2_count: got %0d/%0d want 2/2", obs_rdy.size(), obs_addr.size());
    end else begin
      n_vec++; if (obs_rdy[0] != 2 || obs_rdy[1] != 0) begin n_err++; $display("FAIL burst2_order: got %0d,%0d want 2,0", obs_rdy[0], obs_rdy[1]); end
      n_vec++; if (obs_addr[0] !== 25'h0100600 || obs_addr[1] !== 25'h0100500) begin
        n_err++; $display("FAIL burst2_addr: got %h,%h want 0100600,0100500", obs_addr[0], obs_addr[1]);
      end
    end
  endtask

  task automatic test_newest_wins();
    mem_lat = 6;
    clear_obs();
    tick(3'b100, '0, '0, 21'h700, 1'b0);
    idle_tick();
    tick(3'b001, 21'h10, '0, '0, 1'b0);
    tick(3'b001, 21'h20, '0, '0, 1'b0);
    wait_idle();
    n_vec++;
    if (obs_addr.size() != 2 || obs_rdy.size() != 2) begin
      n_err++; $display("FAIL newest_count: got %0d/%0d want 2/2", obs_addr.size(), obs_rdy.size());
    end else begin
      n_vec++; if (obs_addr[1] !== 25'h0100020) begin n_err++; $display("FAIL newest_addr: got %h want 0100020", obs_addr[1]); end
      n_vec++; if (obs_rdy[0] != 2 || obs_rdy[1] != 0) begin n_err++; $display("FAIL newest_order: got %0d,%0d want 2,0", obs_rdy[0], obs_rdy[1]); end
    end
  endtask

  task automatic test_inflight_rereq();
    mem_lat = 4;
    clear_obs();
    tick(3'b001, 21'h30, '0, '0, 1'b0);
    idle_tick();
    tick(3'b001, 21'h40, '0, '0, 1'b0);
    wait_idle();
    n_vec++;
    if (obs_rdy.size() != 2 || obs_addr.size() != 2) begin
      n_err++; $display("FAIL inflight_count: got %0d/%0d want 2/2", obs_rdy.size(), obs_addr.size());
    end else begin
      n_vec++; if (obs_rdy[0] != 0 || obs_rdy[1] != 0) begin n_err++; $display("FAIL inflight_layer: got %0d,%0d want 0,0", obs_rdy[0], obs_rdy[1]); end
      n_vec++; if (obs_addr[0] !== 25'h0100030 || obs_addr[1] !== 25'h0100040) begin
        n_err++; $display("FAIL inflight_addr: got %h,%h want 0100030,0100040", obs_addr[0], obs_addr[1]);
      end
    end
    n_vec++; if (layer_data !== data_of(25'h0100040)) begin n_err++; $display("FAIL inflight_data: got %h want %h", layer_data, data_of(25'h0100040)); end
  endtask

  task automatic test_reset_busy();
    mem_lat = 4;
    clear_obs();
    tick(3'b010, '0, 21'h50, '0, 1'b0);
    idle_tick();
    tick(3'b000, '0, '0, '0, 1'b1);
    repeat (6) idle_tick();
    n_vec++; if (obs_rdy.size() != 0) begin n_err++; $display("FAIL drain_rdy: got %0d pulses want 0", obs_rdy.size()); end
    n_vec++; if (obs_addr.size() != 1) begin n_err++; $display("FAIL drain_toggles: got %0d want 1", obs_addr.size()); end
    clear_obs();
    tick(3'b100, '0, '0, 21'h60, 1'b0);
    wait_idle();
    n_vec++;
    if (obs_addr.size() != 1 || obs_rdy.size() != 1) begin
      n_err++; $display("FAIL after_drain_count: got %0d/%0d want 1/1", obs_addr.size(), obs_rdy.size());
    end else begin
      n_vec++; if (obs_addr[0] !== 25'h0100060) begin n_err++; $display("FAIL after_drain_addr: got %h want 0100060", obs_addr[0]); end
      n_vec++; if (obs_rdy[0] != 2) begin n_err++; $display("FAIL after_drain_layer: got %0d want 2", obs_rdy[0]); end
    end
  endtask

  task automatic test_wrap();
    mem_lat = 2;
    clear_obs();
    tick(3'b001, 21'h20, '0, '0, 1'b0);
    wait_idle();
    n_vec++;
    if (obs_addr_w.size() != 1) begin
      n_err++; $display("FAIL wrap_count: got %0d want 1", obs_addr_w.size());
    end else begin
      n_vec++; if (obs_addr_w[0] !== 25'h0000010) begin n_err++; $display("FAIL wrap_addr: got %h want 0000010", obs_addr_w[0]); end
      n_vec++; if (obs_addr[0] !== 25'h0100020) begin n_err++; $display("FAIL wrap_base_addr: got %h want 0100020", obs_addr[0]); end
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    rand_lat = 1'b1;
    clear_obs();
    repeat (400) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0);
      tick(r, 21'($urandom), 21'($urandom), 21'($urandom), 1'b0);
      n_vec++; if ($countones(layer_rdy) > 1) begin n_err++; $display("FAIL rand_onehot: got %b want one-hot or zero", layer_rdy); end
    end
    wait_idle();
    rand_lat = 1'b0;
    n_vec++; if (obs_rdy.size() != obs_addr.size()) begin
      n_err++; $display("FAIL rand_balance: got %0d rdy want %0d (one per request)", obs_rdy.size(), obs_addr.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; m_addr[i] = '0; end
    @(negedge CLK_32M);
    test_reset();
    test_single();
    test_all_layers();
    test_newest_wins();
    test_inflight_rereq();
    test_reset_busy();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
